// File: rtl/l2cache_pkg.sv
// -----------------------------------------------------------------------------
// l2cache_pkg
// Shared types and constants for the L2 cache control path.
//   state_e      : controller FSM states
//   SRC_*        : request source codes carried on req_from / rbuf_from
//   OP_*         : cache-operation opcodes carried on rbuf_opcode
// -----------------------------------------------------------------------------
package l2cache_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    UC_W,
    DIRTY_RD,
    DIRTY_CHK,
    WB,
    REFILL_REQ,
    REFILL_WAIT,
    MERGE_W,
    OP
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_I_RD = 2'b01;
  localparam logic [1:0] SRC_D_RD = 2'b10;
  localparam logic [1:0] SRC_D_WR = 2'b11;

  localparam logic [1:0] OP_INIT    = 2'd0;
  localparam logic [1:0] OP_IDX_INV = 2'd1;
  localparam logic [1:0] OP_HIT_INV = 2'd2;

endpackage

// File: rtl/l2_onehot_enc.sv
// -----------------------------------------------------------------------------
// l2_onehot_enc
// Priority encoder for the tag-compare vector. The lowest set bit wins, so a
// (malformed) multi-hit vector still yields a single, deterministic way.
//   onehot_i : WAY-bit hit vector
//   idx_o    : index of the lowest set bit (0 when none set)
//   any_o    : at least one bit set
// -----------------------------------------------------------------------------
module l2_onehot_enc #(
  parameter  int WAY   = 4,
  localparam int WAY_W = $clog2(WAY)
) (
  input  logic [WAY-1:0]   onehot_i,
  output logic [WAY_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the last (lowest) set bit overrides.
  always_comb begin
    idx_o = '0;
    for (int i = WAY - 1; i >= 0; i--) begin
      if (onehot_i[i]) idx_o = WAY_W'(i);
    end
  end

  assign any_o = |onehot_i;

endmodule

// File: rtl/l2cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// l2cache_ctrl_fsm
// Main control FSM of the write-back / write-allocate L2 cache, serving icache
// and dcache requests for any power-of-two associativity WAY (2..16).
//
// Ports (all outputs are combinational from state and inputs):
//   clk, rstn                 clock, asynchronous active-low reset
//   req_*                     new request from upstream
//   rbuf_*                    request buffer contents; rbuf_we loads it
//   ic_/dc_addr_ok/data_ok    upstream handshakes
//   mem_req_r/w, mem_rdy      memory bridge requests / read-data ready
//   mem_addr_ok_r/w, data_ok  memory bridge handshakes
//   hit, victim_way, dirty    tag compare, PLRU victim, dirty-table read data
//   plru_use, data_we, ...    array / PLRU / dirty-table controls
//
// Build option: define L2_PAR_REFILL_EN to issue the refill read request in
// parallel with the writeback instead of strictly after it.
// -----------------------------------------------------------------------------
module l2cache_ctrl_fsm
  import l2cache_pkg::*;
#(
  parameter  int WAY   = 4,
  localparam int WAY_W = $clog2(WAY)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_from,
  input  logic             req_uc,
  input  logic             req_op,
  input  logic [1:0]       rbuf_from,
  input  logic             rbuf_uc,
  input  logic             rbuf_op,
  input  logic [1:0]       rbuf_opcode,
  input  logic [WAY_W-1:0] rbuf_op_way,
  output logic             rbuf_we,
  output logic             ic_addr_ok,
  output logic             ic_data_ok,
  output logic             dc_addr_ok,
  output logic             dc_data_ok,
  output logic             mem_req_r,
  output logic             mem_req_w,
  output logic             mem_rdy,
  input  logic             mem_addr_ok_r,
  input  logic             mem_addr_ok_w,
  input  logic             mem_data_ok,
  input  logic [WAY-1:0]   hit,
  input  logic [WAY_W-1:0] victim_way,
  input  logic             dirty,
  output logic [WAY-1:0]   plru_use,
  output logic [WAY-1:0]   data_we,
  output logic             data_refill,
  output logic [WAY-1:0]   tagv_inval,
  output logic             tagv_init,
  output logic             wb_read,
  output logic [WAY_W-1:0] way_sel,
  output logic [WAY_W-1:0] dirty_way,
  output logic             dirty_set1,
  output logic             dirty_set0,
  output logic             ret_from_mem
);

  localparam logic [WAY-1:0] ONE = WAY'(1);

  state_e           state_q, state_d;
  logic [WAY_W-1:0] vway_q, vway_d;   // victim latched at miss, stable through refill
  logic [WAY_W-1:0] hway_q, hway_d;   // hit way latched for hit-invalidate ops

  logic [WAY_W-1:0] h_idx;
  logic             h_any;
  logic [WAY-1:0]   h_oh;             // cleaned one-hot of the winning way
  logic [WAY_W-1:0] tgt_way;
  logic             new_req;
  logic             new_ic_aok, new_dc_aok;
  logic             rb_ic_rd, rb_dc_rd, rb_wr;

  l2_onehot_enc #(.WAY(WAY)) u_hit_enc (
    .onehot_i (hit),
    .idx_o    (h_idx),
    .any_o    (h_any)
  );

  assign h_oh    = ONE << h_idx;
  assign tgt_way = !rbuf_op                   ? vway_q      :
                   (rbuf_opcode == OP_IDX_INV) ? rbuf_op_way : hway_q;

  // An uncached write is only acknowledged once memory takes its address.
  assign new_req    = (req_from != SRC_NONE) && !req_op;
  assign new_ic_aok = (req_from == SRC_I_RD);
  assign new_dc_aok = (req_from == SRC_D_RD) || ((req_from == SRC_D_WR) && !req_uc);

  assign rb_ic_rd = (rbuf_from == SRC_I_RD);
  assign rb_dc_rd = (rbuf_from == SRC_D_RD);
  assign rb_wr    = (rbuf_from == SRC_D_WR);

`ifdef L2_PAR_REFILL_EN
  logic rd_acc_q, rd_acc_d;           // refill read address already accepted during WB
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      vway_q   <= '0;
      hway_q   <= '0;
`ifdef L2_PAR_REFILL_EN
      rd_acc_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vway_q   <= vway_d;
      hway_q   <= hway_d;
`ifdef L2_PAR_REFILL_EN
      rd_acc_q <= rd_acc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    vway_d   = vway_q;
    hway_d   = hway_q;
`ifdef L2_PAR_REFILL_EN
    rd_acc_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_op)                     state_d = OP;
        else if (req_from != SRC_NONE)  state_d = LOOKUP;
      end
      LOOKUP: begin
        if (rbuf_uc) begin
          state_d = rb_wr ? UC_W : REFILL_REQ;
        end else if (h_any) begin
          state_d = new_req ? LOOKUP : IDLE;
        end else begin
          vway_d  = victim_way;
          state_d = DIRTY_RD;
        end
      end
      UC_W: begin
        if (mem_addr_ok_w) state_d = IDLE;
      end
      DIRTY_RD: state_d = DIRTY_CHK;
      DIRTY_CHK: begin
        if (dirty)        state_d = WB;
        else if (rbuf_op) state_d = IDLE;
        else              state_d = REFILL_REQ;
      end
      WB: begin
`ifdef L2_PAR_REFILL_EN
        rd_acc_d = !rbuf_op && (rd_acc_q || mem_addr_ok_r);
        if (mem_addr_ok_w) begin
          if (rbuf_op)                         state_d = IDLE;
          else if (rd_acc_q || mem_addr_ok_r)  state_d = REFILL_WAIT;
          else                                 state_d = REFILL_REQ;
          rd_acc_d = 1'b0;
        end
`else
        if (mem_addr_ok_w) state_d = rbuf_op ? IDLE : REFILL_REQ;
`endif
      end
      REFILL_REQ: begin
        if (mem_addr_ok_r || mem_data_ok) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_data_ok) state_d = (!rbuf_uc && rb_wr) ? MERGE_W : IDLE;
      end
      MERGE_W: state_d = IDLE;
      OP: begin
        case (rbuf_opcode)
          OP_IDX_INV: state_d = DIRTY_RD;
          OP_HIT_INV: begin
            if (h_any) begin
              hway_d  = h_idx;
              state_d = DIRTY_RD;
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rbuf_we      = 1'b0;
    ic_addr_ok   = 1'b0;
    ic_data_ok   = 1'b0;
    dc_addr_ok   = 1'b0;
    dc_data_ok   = 1'b0;
    mem_req_r    = 1'b0;
    mem_req_w    = 1'b0;
    mem_rdy      = 1'b0;
    plru_use     = '0;
    data_we      = '0;
    data_refill  = 1'b0;
    tagv_inval   = '0;
    tagv_init    = 1'b0;
    wb_read      = 1'b0;
    way_sel      = '0;
    dirty_way    = '0;
    dirty_set1   = 1'b0;
    dirty_set0   = 1'b0;
    ret_from_mem = 1'b0;
    case (state_q)
      IDLE: begin
        rbuf_we    = 1'b1;
        ic_addr_ok = new_ic_aok;
        dc_addr_ok = new_dc_aok;
      end
      LOOKUP: begin
        if (!rbuf_uc && h_any) begin
          plru_use = h_oh;
          if (rb_wr) begin
            data_we    = h_oh;
            dirty_way  = h_idx;
            dirty_set1 = 1'b1;
          end else begin
            way_sel    = h_idx;
            ic_data_ok = rb_ic_rd;
            dc_data_ok = rb_dc_rd;
          end
          // Hit-under-hit: take the next request while this one completes.
          if (new_req) begin
            rbuf_we    = 1'b1;
            ic_addr_ok = new_ic_aok;
            dc_addr_ok = new_dc_aok;
          end
        end
      end
      UC_W: begin
        mem_req_w  = 1'b1;
        dc_addr_ok = mem_addr_ok_w;
      end
      DIRTY_RD: dirty_way = tgt_way;
      DIRTY_CHK: begin
        // Hold the dirty-table address; its data arrives this cycle.
        dirty_way = tgt_way;
        if (dirty) begin
          wb_read = 1'b1;
          way_sel = tgt_way;
        end
      end
      WB: begin
        mem_req_w = 1'b1;
        way_sel   = tgt_way;
        wb_read   = !mem_addr_ok_w;
`ifdef L2_PAR_REFILL_EN
        mem_req_r = !rbuf_op && !rd_acc_q;
`endif
      end
      REFILL_REQ: mem_req_r = 1'b1;
      REFILL_WAIT: begin
        mem_rdy = 1'b1;
        if (!rbuf_uc) way_sel = vway_q;
        if (mem_data_ok) begin
          ret_from_mem = 1'b1;
          if (!rbuf_uc) begin
            data_refill = 1'b1;
            data_we     = ONE << vway_q;
            dirty_way   = vway_q;
            dirty_set0  = 1'b1;
          end
          if (!rb_wr) begin
            if (!rbuf_uc) plru_use = ONE << vway_q;
            ic_data_ok = rb_ic_rd;
            dc_data_ok = rb_dc_rd;
            rbuf_we    = 1'b1;
          end
        end
      end
      MERGE_W: begin
        way_sel    = vway_q;
        data_we    = ONE << vway_q;
        plru_use   = ONE << vway_q;
        dirty_way  = vway_q;
        dirty_set1 = 1'b1;
      end
      OP: begin
        case (rbuf_opcode)
          OP_INIT:    tagv_init  = 1'b1;
          OP_IDX_INV: tagv_inval = ONE << rbuf_op_way;
          OP_HIT_INV: if (h_any) tagv_inval = h_oh;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2cache_ctrl_fsm.sv
module tb_l2cache_ctrl_fsm;
  import l2cache_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] req_from, rbuf_from, rbuf_opcode;
  logic       req_uc, req_op, rbuf_uc, rbuf_op;
  logic [1:0] rbuf_op_way, victim_way, way_sel, dirty_way;
  logic       rbuf_we, ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok;
  logic       mem_req_r, mem_req_w, mem_rdy;
  logic       mem_addr_ok_r, mem_addr_ok_w, mem_data_ok;
  logic [3:0] hit, plru_use, data_we, tagv_inval;
  logic       dirty, data_refill, tagv_init, wb_read, dirty_set1, dirty_set0, ret_from_mem;

  l2cache_ctrl_fsm #(.WAY(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_from(req_from), .req_uc(req_uc), .req_op(req_op),
    .rbuf_from(rbuf_from), .rbuf_uc(rbuf_uc), .rbuf_op(rbuf_op),
    .rbuf_opcode(rbuf_opcode), .rbuf_op_way(rbuf_op_way), .rbuf_we(rbuf_we),
    .ic_addr_ok(ic_addr_ok), .ic_data_ok(ic_data_ok),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok),
    .mem_req_r(mem_req_r), .mem_req_w(mem_req_w), .mem_rdy(mem_rdy),
    .mem_addr_ok_r(mem_addr_ok_r), .mem_addr_ok_w(mem_addr_ok_w), .mem_data_ok(mem_data_ok),
    .hit(hit), .victim_way(victim_way), .dirty(dirty),
    .plru_use(plru_use), .data_we(data_we), .data_refill(data_refill),
    .tagv_inval(tagv_inval), .tagv_init(tagv_init), .wb_read(wb_read),
    .way_sel(way_sel), .dirty_way(dirty_way),
    .dirty_set1(dirty_set1), .dirty_set0(dirty_set0), .ret_from_mem(ret_from_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ret;
    logic       tinit;
    logic [3:0] tinv;
    logic [1:0] dway;
    logic       ds0;
    logic       ds1;
    logic [3:0] plru;
    logic       refill;
    logic [3:0] dwe;
    logic [1:0] wsel;
    logic       dcd;
    logic       dca;
    logic       icd;
    logic       ica;
  } ev_t;

  ev_t sb[$];
  ev_t mon_act, mon_exp;
  int  checks = 0;
  int  failures = 0;

  function automatic ev_t mk(input logic ica, input logic icd, input logic dca, input logic dcd,
                             input logic [1:0] wsel, input logic [3:0] dwe, input logic refill,
                             input logic [3:0] plru, input logic ds1, input logic ds0,
                             input logic [1:0] dway, input logic [3:0] tinv,
                             input logic tinit, input logic ret);
    ev_t e;
    e.ica = ica; e.icd = icd; e.dca = dca; e.dcd = dcd; e.wsel = wsel; e.dwe = dwe;
    e.refill = refill; e.plru = plru; e.ds1 = ds1; e.ds0 = ds0; e.dway = dway;
    e.tinv = tinv; e.tinit = tinit; e.ret = ret;
    return e;
  endfunction

  // Monitor: every cycle with a visible handshake or array update is one event.
  always @(negedge clk) begin
    if (rstn && (ic_addr_ok || ic_data_ok || dc_addr_ok || dc_data_ok || (|data_we) ||
                 (|tagv_inval) || tagv_init || dirty_set0 || dirty_set1)) begin
      mon_act = mk(ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok, way_sel, data_we,
                   data_refill, plru_use, dirty_set1, dirty_set0, dirty_way, tagv_inval,
                   tagv_init, ret_from_mem);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event t=%0t got=%h want=<none>", $time, mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL event t=%0t got=%h want=%h", $time, mon_act, mon_exp);
        end else begin
          $display("event ok t=%0t val=%h", $time, mon_act);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end else begin
      $display("check ok %s t=%0t val=%h", name, $time, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_from = SRC_NONE; req_uc = 0; req_op = 0;
    rbuf_from = SRC_NONE; rbuf_uc = 0; rbuf_op = 0; rbuf_opcode = 0; rbuf_op_way = 0;
    mem_addr_ok_r = 0; mem_addr_ok_w = 0; mem_data_ok = 0;
    hit = 0; victim_way = 0; dirty = 0;
  endtask

  // IDLE signature: {mem_req_r, mem_req_w, mem_rdy, rbuf_we}
  task automatic chk_idle(input string name);
    @(negedge clk);
    chk(name, {28'd0, mem_req_r, mem_req_w, mem_rdy, rbuf_we}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1);
  end

  initial begin
    int wbc, wbr;
    clr();
    rstn = 0;
    repeat (2) @(posedge clk);
    chk_idle("reset_state");
    step(); rstn = 1;

    // T1: d-read hit on way 2
    step(); clr(); req_from = SRC_D_RD;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_RD; hit = 4'b0100;
    sb.push_back(mk(0,0,0,1, 2'd2, 4'b0000, 0, 4'b0100, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr();
    chk_idle("t1_back_idle");

    // T2: back-to-back d-write hits, way1 then way3
    step(); clr(); req_from = SRC_D_WR;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_WR; hit = 4'b0010; req_from = SRC_D_WR;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0010, 0, 4'b0010, 1,0, 2'd1, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_WR; hit = 4'b1000;
    sb.push_back(mk(0,0,0,0, 2'd0, 4'b1000, 0, 4'b1000, 1,0, 2'd3, 4'b0000, 0,0));
    step(); clr();
    chk_idle("t2_back_idle");

    // T3: d-read miss, victim 3 dirty, writeback accepted on 4th WB cycle
    step(); clr(); req_from = SRC_D_RD;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_RD; victim_way = 2'd3;
    step(); clr(); rbuf_from = SRC_D_RD;
    @(negedge clk); chk("t3_dirty_rd_way", 32'(dirty_way), 32'd3);
    step(); clr(); rbuf_from = SRC_D_RD; dirty = 1;
    @(negedge clk); chk("t3_chk_wb_read", {30'd0, wb_read, mem_req_w}, 32'h2);
    chk("t3_chk_way_sel", 32'(way_sel), 32'd3);
    wbc = 0; wbr = 0;
    for (int i = 0; i < 4; i++) begin
      step(); clr(); rbuf_from = SRC_D_RD; mem_addr_ok_w = (i == 3);
      @(negedge clk);
      if (mem_req_w) wbc++;
      if (wb_read && way_sel == 2'd3) wbr++;
    end
    chk("t3_wb_cycles", 32'(wbc), 32'd4);
    chk("t3_wb_read_cycles", 32'(wbr), 32'd3);
    step(); clr(); rbuf_from = SRC_D_RD;
    @(negedge clk); chk("t3_refill_req", {30'd0, mem_req_r, mem_req_w}, 32'h2);
    mem_addr_ok_r = 1;
    step(); clr(); rbuf_from = SRC_D_RD;
    @(negedge clk); chk("t3_refill_wait_rdy", {31'd0, mem_rdy}, 32'h1);
    step(); clr(); rbuf_from = SRC_D_RD; mem_data_ok = 1;
    sb.push_back(mk(0,0,0,1, 2'd3, 4'b1000, 1, 4'b1000, 0,1, 2'd3, 4'b0000, 0,1));
    step(); clr();
    chk_idle("t3_back_idle");

    // T4: uncached d-write
    step(); clr(); req_from = SRC_D_WR; req_uc = 1;
    @(negedge clk); chk("t4_no_addr_ok_idle", {31'd0, dc_addr_ok}, 32'h0);
    step(); clr(); rbuf_from = SRC_D_WR; rbuf_uc = 1;
    step(); clr(); rbuf_from = SRC_D_WR; rbuf_uc = 1;
    @(negedge clk); chk("t4_ucw_req", {30'd0, mem_req_w, dc_addr_ok}, 32'h2);
    step(); clr(); rbuf_from = SRC_D_WR; rbuf_uc = 1; mem_addr_ok_w = 1;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr();
    chk_idle("t4_back_idle");

    // T5: hit-invalidate op, hit way 1, clean
    step(); clr(); req_from = SRC_D_RD; req_op = 1;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_op = 1; rbuf_opcode = OP_HIT_INV; hit = 4'b0010;
    sb.push_back(mk(0,0,0,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0010, 0,0));
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_op = 1; rbuf_opcode = OP_HIT_INV;
    @(negedge clk); chk("t5_dirty_way", {29'd0, mem_req_w, dirty_way}, 32'h1);
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_op = 1; rbuf_opcode = OP_HIT_INV; dirty = 0;
    @(negedge clk); chk("t5_clean_no_wb", {30'd0, mem_req_w, wb_read}, 32'h0);
    step(); clr();
    chk_idle("t5_back_idle");

    // T6: init op
    step(); clr(); req_op = 1;
    step(); clr(); rbuf_op = 1; rbuf_opcode = OP_INIT;
    sb.push_back(mk(0,0,0,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 1,0));
    step(); clr();
    chk_idle("t6_back_idle");

    // T7: i-read with multi-hit 0110 -> lowest (way 1) wins
    step(); clr(); req_from = SRC_I_RD;
    sb.push_back(mk(1,0,0,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_I_RD; hit = 4'b0110;
    sb.push_back(mk(0,1,0,0, 2'd1, 4'b0000, 0, 4'b0010, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr();

    // T8: clean write miss, victim 1 latched while victim_way input moves
    step(); clr(); req_from = SRC_D_WR;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd1;
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd2;
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd2; dirty = 0;
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd2; mem_addr_ok_r = 1; mem_data_ok = 1;
    @(negedge clk); chk("t8_refill_req_simul", {30'd0, mem_req_r, mem_req_w}, 32'h2);
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd2; mem_data_ok = 1;
    sb.push_back(mk(0,0,0,0, 2'd1, 4'b0010, 1, 4'b0000, 0,1, 2'd1, 4'b0000, 0,1));
    step(); clr(); rbuf_from = SRC_D_WR; victim_way = 2'd2;
    sb.push_back(mk(0,0,0,0, 2'd1, 4'b0010, 0, 4'b0010, 1,0, 2'd1, 4'b0000, 0,0));
    step(); clr();
    chk_idle("t8_back_idle");

    // T9: reset asserted during REFILL_WAIT of an uncached read
    step(); clr(); req_from = SRC_D_RD; req_uc = 1;
    sb.push_back(mk(0,0,1,0, 2'd0, 4'b0000, 0, 4'b0000, 0,0, 2'd0, 4'b0000, 0,0));
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_uc = 1;
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_uc = 1; mem_addr_ok_r = 1;
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_uc = 1;
    @(negedge clk); chk("t9_wait_rdy", {31'd0, mem_rdy}, 32'h1);
    step(); clr(); rbuf_from = SRC_D_RD; rbuf_uc = 1; rstn = 0;
    @(negedge clk); chk("t9_reset_drop", {29'd0, mem_req_r, mem_req_w, mem_rdy}, 32'h0);
    step(); rstn = 1; clr(); rbuf_from = SRC_D_RD; rbuf_uc = 1; mem_data_ok = 1;
    @(negedge clk); chk("t9_no_late_data", {26'd0, data_we, mem_rdy, dc_data_ok}, 32'h0);
    step(); clr();

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
